// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter for 74x164/74x595 style shift-register chains.
// Each frame is a clear pulse, DATA_BITS serial clocks and then a latch strobe.
module p2s_serializer #(
    parameter int DATA_BITS = 16,
    parameter int DIR       = 0,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [DATA_BITS-1:0] PData,
    output logic                 s_clk,
    output logic                 s_clrn,
    output logic                 sout,
    output logic                 s_lat,
    output logic                 EN,
    output logic                 done
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_BITS);

    typedef enum logic [2:0] {IDLE, CLR, LOW, HIGH, LATCH} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 s_clk_q, s_clk_d;
    logic                 s_clrn_q, s_clrn_d;
    logic                 sout_q, sout_d;
    logic                 s_lat_q, s_lat_d;
    logic                 en_q, en_d;
    logic                 done_q, done_d;
    logic                 div_last;

    assign div_last = (div_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    sreg_d    = PData;
                    bit_cnt_d = BIT_LOAD;
                    state_d   = CLR;
                end
            end
            CLR: begin
                div_cnt_d = DIV_LOAD;
                state_d   = LOW;
            end
            LOW: begin
                if (div_last) begin
                    div_cnt_d = DIV_LOAD;
                    state_d   = HIGH;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end
            end
            HIGH: begin
                if (div_last) begin
                    // The shift happens on leaving HIGH so sout can only move while s_clk is low.
                    sreg_d    = (DIR == 0) ? (sreg_q << 1) : (sreg_q >> 1);
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    div_cnt_d = DIV_LOAD;
                    state_d   = (bit_cnt_q == BIT_W'(1)) ? LATCH : LOW;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    state_d = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        s_clk_d  = (state_d == HIGH);
        s_clrn_d = (state_d != CLR);
        s_lat_d  = (state_d == LATCH);
        en_d     = (state_d == IDLE);
        done_d   = (state_q == LATCH) && (state_d == IDLE);
        sout_d   = 1'b0;
        if (state_d == LOW || state_d == HIGH) begin
            sout_d = (DIR == 0) ? sreg_d[DATA_BITS-1] : sreg_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            s_clk_q   <= 1'b0;
            s_clrn_q  <= 1'b1;
            sout_q    <= 1'b0;
            s_lat_q   <= 1'b0;
            en_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            s_clk_q   <= s_clk_d;
            s_clrn_q  <= s_clrn_d;
            sout_q    <= sout_d;
            s_lat_q   <= s_lat_d;
            en_q      <= en_d;
            done_q    <= done_d;
        end
    end

    assign s_clk  = s_clk_q;
    assign s_clrn = s_clrn_q;
    assign sout   = sout_q;
    assign s_lat  = s_lat_q;
    assign EN     = en_q;
    assign done   = done_q;

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: three configurations checked every cycle against a frame-timeline
// model, plus directed frames with hand-computed bit patterns and latencies.
module tb_p2s_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [15:0] pdata [3];
    logic [2:0]  s_clk, s_clrn, sout, s_lat, en, done;

    int compared = 0;
    int mismatched = 0;

    // Instance 0: 16b MSB first div 2; instance 1: 16b LSB first div 2; instance 2: 8b MSB first div 1.
    int db_of  [3] = '{16, 16, 8};
    int cd_of  [3] = '{2, 2, 1};
    int dir_of [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    p2s_serializer #(.DATA_BITS(16), .DIR(0), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .Start(start[0]), .PData(pdata[0]),
        .s_clk(s_clk[0]), .s_clrn(s_clrn[0]), .sout(sout[0]), .s_lat(s_lat[0]),
        .EN(en[0]), .done(done[0]));

    p2s_serializer #(.DATA_BITS(16), .DIR(1), .CLK_DIV(2)) dut1 (
        .clk(clk), .rst(rst), .Start(start[1]), .PData(pdata[1]),
        .s_clk(s_clk[1]), .s_clrn(s_clrn[1]), .sout(sout[1]), .s_lat(s_lat[1]),
        .EN(en[1]), .done(done[1]));

    p2s_serializer #(.DATA_BITS(8), .DIR(0), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .Start(start[2]), .PData(pdata[2][7:0]),
        .s_clk(s_clk[2]), .s_clrn(s_clrn[2]), .sout(sout[2]), .s_lat(s_lat[2]),
        .EN(en[2]), .done(done[2]));

    // Model: each frame is a timeline indexed by cycles since the accept edge.
    bit          m_active [3] = '{0, 0, 0};
    int          m_off    [3] = '{0, 0, 0};
    logic [15:0] m_data   [3];

    function automatic int frame_len(int i);
        return 1 + 2 * cd_of[i] * db_of[i] + cd_of[i];
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_active[i] = 0;
                m_off[i]    = 0;
            end else if ((!m_active[i] || m_off[i] == frame_len(i)) && start[i]) begin
                m_active[i] = 1;
                m_off[i]    = 0;
                m_data[i]   = pdata[i];
            end else if (m_active[i]) begin
                if (m_off[i] == frame_len(i)) m_active[i] = 0;
                else m_off[i] = m_off[i] + 1;
            end
        end
    end

    // Expected {s_clk, s_clrn, sout, s_lat, EN, done}.
    function automatic logic [5:0] model_out(int i);
        int db, cd, off, j, b;
        logic bitv;
        db  = db_of[i];
        cd  = cd_of[i];
        off = m_off[i];
        if (!m_active[i]) return 6'b010010;
        if (off == 0) return 6'b000000;
        if (off <= 2 * cd * db) begin
            j    = off - 1;
            b    = j / (2 * cd);
            bitv = (dir_of[i] == 1) ? m_data[i][b] : m_data[i][db - 1 - b];
            return {((j % (2 * cd)) >= cd), 1'b1, bitv, 3'b000};
        end
        if (off < frame_len(i)) return 6'b010100;
        return 6'b010011;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [5:0] exp_v, act_v;
            exp_v = model_out(i);
            act_v = {s_clk[i], s_clrn[i], sout[i], s_lat[i], en[i], done[i]};
            compared++;
            if (act_v !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL model inst%0d t=%0t {s_clk,s_clrn,sout,s_lat,EN,done} got %b want %b",
                         i, $time, act_v, exp_v);
            end
        end
    end

    task automatic check_output(input string name, input int act, input int exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s got 0x%0h want 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic [15:0] data);
        @(posedge clk);
        #2;
        start[i] = 1'b1;
        pdata[i] = data;
        @(posedge clk);
        #2;
        start[i] = 1'b0;
        @(negedge clk);
    endtask

    // Called at the negedge of the CLR cycle; returns at the negedge where done is seen.
    task automatic capture_frame(input int i, input int abort_at, input bit poke,
                                 output int latency, output int rx, output int lat_cnt,
                                 output int clrn_cnt, output int clk_hi);
        logic prev_clk;
        latency  = -1;
        rx       = 0;
        lat_cnt  = 0;
        clrn_cnt = 0;
        clk_hi   = 0;
        prev_clk = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (n > 0) @(negedge clk);
            if (s_clk[i] && !prev_clk) rx = ((rx << 1) | int'(sout[i])) & 32'hFFFF;
            prev_clk = s_clk[i];
            if (s_clk[i]) clk_hi++;
            if (s_lat[i]) lat_cnt++;
            if (!s_clrn[i]) clrn_cnt++;
            if (done[i]) begin
                latency = n;
                break;
            end
            if (poke && (n == 5 || n == 30)) begin
                start[i] = 1'b1;
                pdata[i] = 16'hFFFF;
            end else if (poke && (n == 6 || n == 31)) begin
                start[i] = 1'b0;
            end
            if (abort_at >= 0) begin
                if (n == abort_at) begin
                    #2 rst = 1'b0;
                    #1;
                    check_output("abort s_clk", int'(s_clk[i]), 0);
                    check_output("abort s_clrn", int'(s_clrn[i]), 1);
                    check_output("abort sout", int'(sout[i]), 0);
                    check_output("abort s_lat", int'(s_lat[i]), 0);
                    check_output("abort EN", int'(en[i]), 1);
                end else if (n == abort_at + 2) begin
                    rst = 1'b1;
                end else if (n == abort_at + 80) begin
                    break;
                end
            end
        end
    endtask

    initial begin
        int lat, rx, latc, clrnc, hi;
        start = '0;
        for (int i = 0; i < 3; i++) pdata[i] = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_output("reset EN", int'(en), 7);
        check_output("reset s_clrn", int'(s_clrn), 7);
        check_output("reset s_clk|sout|s_lat|done", int'(s_clk | sout | s_lat | done), 0);
        rst = 1'b1;

        $display("[TB] frame A5C3 MSB first");
        apply_stimulus(0, 16'hA5C3);
        capture_frame(0, -1, 0, lat, rx, latc, clrnc, hi);
        check_output("t1 bits", rx, 16'hA5C3);
        check_output("t1 latency", lat, 67);
        check_output("t1 s_lat cycles", latc, 2);
        check_output("t1 s_clrn low cycles", clrnc, 1);
        check_output("t1 s_clk high cycles", hi, 32);

        $display("[TB] frame A5C3 LSB first");
        apply_stimulus(1, 16'hA5C3);
        capture_frame(1, -1, 0, lat, rx, latc, clrnc, hi);
        check_output("t2 bits", rx, 16'hC3A5);
        check_output("t2 latency", lat, 67);
        check_output("t2 s_lat cycles", latc, 2);

        $display("[TB] Start pulses during a frame");
        apply_stimulus(0, 16'hA5C3);
        capture_frame(0, -1, 1, lat, rx, latc, clrnc, hi);
        check_output("t3 bits", rx, 16'hA5C3);
        check_output("t3 latency", lat, 67);
        repeat (5) @(negedge clk);
        check_output("t3 no second frame EN", int'(en[0]), 1);

        $display("[TB] reset during the 7th HIGH phase");
        apply_stimulus(0, 16'hA5C3);
        capture_frame(0, 27, 0, lat, rx, latc, clrnc, hi);
        check_output("t4 no done", lat, -1);
        check_output("t4 no s_lat", latc, 0);
        apply_stimulus(0, 16'h3C96);
        capture_frame(0, -1, 0, lat, rx, latc, clrnc, hi);
        check_output("t4 recovery bits", rx, 16'h3C96);
        check_output("t4 recovery latency", lat, 67);

        $display("[TB] back-to-back frames");
        @(posedge clk);
        #2;
        start[0] = 1'b1;
        pdata[0] = 16'h0001;
        @(posedge clk);
        #2 pdata[0] = 16'h8000;
        @(negedge clk);
        capture_frame(0, -1, 0, lat, rx, latc, clrnc, hi);
        check_output("t5 first bits", rx, 16'h0001);
        check_output("t5 EN in done cycle", int'(en[0]), 1);
        @(negedge clk);
        check_output("t5 EN low after one idle cycle", int'(en[0]), 0);
        capture_frame(0, -1, 0, lat, rx, latc, clrnc, hi);
        start[0] = 1'b0;
        check_output("t5 second bits", rx, 16'h8000);
        check_output("t5 second latency", lat, 67);

        $display("[TB] 8-bit frame with divide-by-1");
        apply_stimulus(2, 16'h00FF);
        capture_frame(2, -1, 0, lat, rx, latc, clrnc, hi);
        check_output("t6 bits", rx, 16'h00FF);
        check_output("t6 latency", lat, 18);
        check_output("t6 s_clk high cycles", hi, 8);
        check_output("t6 s_lat cycles", latc, 1);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
